// File: rtl/mem_pkg.sv
// Shared definitions for the memory_sync_param slice.
//   state_e        : zero-fill controller states (INIT, IDLE)
//   DEF_*          : default geometry of the RAM
//   lanes()        : number of byte lanes in a word of the given width
package mem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_ADDR_W = 3;

  function automatic int lanes(input int data_w);
    return data_w / 8;
  endfunction

  localparam int DEF_LANES = lanes(DEF_DATA_W);

endpackage

// File: rtl/memory_sync_param_if.sv
// Request/response bundle of the synchronous RAM.
//   master : requester (drives enable, R_W, clear, Address, D_In, Byte_En)
//   slave  : RAM (drives ready, D_Out, valid, err)
interface memory_sync_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) ();

  logic                  enable;
  logic                  R_W;
  logic                  clear;
  logic [ADDR_W-1:0]     Address;
  logic [DATA_W-1:0]     D_In;
  logic [DATA_W/8-1:0]   Byte_En;
  logic                  ready;
  logic [DATA_W-1:0]     D_Out;
  logic                  valid;
  logic                  err;

  modport master (
    output enable, R_W, clear, Address, D_In, Byte_En,
    input  ready, D_Out, valid, err
  );

  modport slave (
    input  enable, R_W, clear, Address, D_In, Byte_En,
    output ready, D_Out, valid, err
  );

endinterface

// File: rtl/memory_init_ctrl.sv
// Zero-fill controller: walks the array one word per cycle after reset or
// on clear, then sits in IDLE with ready asserted.
//   clk, rst_n : clock, async active-low reset
//   clear      : zero-fill request (honoured in IDLE only)
//   ready      : registered, high only while IDLE
//   fill_we    : write strobe for the zero-fill
//   fill_addr  : word being cleared
import mem_pkg::*;

module memory_init_ctrl #(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  output logic              ready,
  output logic              fill_we,
  output logic [ADDR_W-1:0] fill_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ready_q, ready_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ready_d   = ready_q;
    fill_we   = 1'b0;
    fill_addr = ptr_q;
    case (state_q)
      INIT: begin
        fill_we = 1'b1;
        if (ptr_q == LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
          ready_d = 1'b1;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (clear) begin
          state_d = INIT;
          ptr_d   = '0;
          ready_d = 1'b0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign ready = ready_q;

endmodule

// File: rtl/memory_sync_param.sv
// Parametrised single-port synchronous RAM with per-byte write enables,
// registered read data with a valid strobe, out-of-range error strobe and
// a self-clearing zero-fill after reset or on clear.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of memory_sync_param_if (request in, ready/D_Out/valid/err out)
// Mem is kept at top level so it can be dumped hierarchically.
import mem_pkg::*;

module memory_sync_param #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  memory_sync_param_if.slave   bus
);

  localparam int              LANES   = lanes(DATA_W);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] Mem [DEPTH];

  logic              ready;
  logic              fill_we;
  logic [ADDR_W-1:0] fill_addr;

  logic              accept;
  logic              in_range;
  logic [DATA_W-1:0] rd_word;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic [DATA_W-1:0] d_out_q, d_out_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  memory_init_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_init_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (bus.clear),
    .ready     (ready),
    .fill_we   (fill_we),
    .fill_addr (fill_addr)
  );

  // clear wins over a same-cycle request; ready is low throughout INIT, so
  // fill and user writes never collide.
  assign accept   = ready && bus.enable && !bus.clear;
  assign in_range = {1'b0, bus.Address} < DEPTH_C;
  assign rd_word  = in_range ? Mem[bus.Address] : '0;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = fill_addr;
    wr_data = '0;
    d_out_d = d_out_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    if (fill_we) begin
      wr_en = 1'b1;
    end else if (accept) begin
      if (!in_range) begin
        err_d = 1'b1;
        if (bus.R_W) d_out_d = '0;
      end else if (bus.R_W) begin
        d_out_d = rd_word;
        valid_d = 1'b1;
      end else begin
        // Byte-lane merge: untouched lanes keep the stored word.
        wr_en   = 1'b1;
        wr_addr = bus.Address;
        wr_data = rd_word;
        for (int unsigned i = 0; i < LANES; i++) begin
          if (bus.Byte_En[i]) wr_data[8*i +: 8] = bus.D_In[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) Mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_out_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      d_out_q <= d_out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.ready = ready;
  assign bus.D_Out = d_out_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_memory_sync_param.sv
// Self-checking bench for memory_sync_param: instance A (32x8) for the main
// function, instance B (32x6, ADDR_W=3) for out-of-range handling.
module tb_memory_sync_param;

  logic clk;
  logic rst_n;

  memory_sync_param_if #(.DATA_W(32), .ADDR_W(3)) ifa ();
  memory_sync_param_if #(.DATA_W(32), .ADDR_W(3)) ifb ();

  memory_sync_param #(.DATA_W(32), .DEPTH(8), .ADDR_W(3)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  memory_sync_param #(.DATA_W(32), .DEPTH(6), .ADDR_W(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        en;
    logic        rw;
    logic [2:0]  addr;
    logic [31:0] din;
    logic [3:0]  be;
    logic        exp_valid;
    logic        exp_err;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_a(input logic en, input logic rw, input logic cl, input logic [2:0] addr,
                         input logic [31:0] din, input logic [3:0] be);
    ifa.enable = en; ifa.R_W = rw; ifa.clear = cl;
    ifa.Address = addr; ifa.D_In = din; ifa.Byte_En = be;
  endtask

  task automatic drive_b(input logic en, input logic rw, input logic [2:0] addr,
                         input logic [31:0] din, input logic [3:0] be);
    ifb.enable = en; ifb.R_W = rw; ifb.clear = 1'b0;
    ifb.Address = addr; ifb.D_In = din; ifb.Byte_En = be;
  endtask

  // Steps until A is ready (bounded); requests driven on A must be ignored.
  task automatic run_init(output int na, output int nb);
    na = 0;
    nb = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      chk("init_valid", 32'(ifa.valid), 32'd0);
      chk("init_err", 32'(ifa.err), 32'd0);
      if (nb == 0 && ifb.ready === 1'b1) nb = c;
      if (ifa.ready === 1'b1) begin
        na = c;
        break;
      end
    end
  endtask

  // Reads every word of A on consecutive cycles and compares against exp.
  task automatic read_all_a(input string nm, input logic [31:0] exp [8]);
    for (int a = 0; a < 8; a++) begin
      drive_a(1'b1, 1'b1, 1'b0, 3'(a), 32'h0, 4'h0);
      step();
      chk($sformatf("%s_valid[%0d]", nm, a), 32'(ifa.valid), 32'd1);
      chk($sformatf("%s_dout[%0d]", nm, a), ifa.D_Out, exp[a]);
    end
    drive_a(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
  endtask

  initial begin
    int na, nb;
    logic [31:0] zeros [8];
    logic [31:0] seq [8];
    foreach (zeros[i]) zeros[i] = '0;
    foreach (seq[i]) seq[i] = 32'h11111111 * i;

    // IDLE-phase vectors on A (array starts all zero).
    vecs.push_back('{1'b1, 1'b0, 3'd3, 32'hAAAA5555, 4'hF, 1'b0, 1'b0, 32'h00000000});
    vecs.push_back('{1'b1, 1'b0, 3'd3, 32'h0000BB00, 4'h2, 1'b0, 1'b0, 32'h00000000});
    vecs.push_back('{1'b1, 1'b1, 3'd3, 32'h00000000, 4'h0, 1'b1, 1'b0, 32'hAAAABB55});
    vecs.push_back('{1'b0, 1'b1, 3'd3, 32'h00000000, 4'h0, 1'b0, 1'b0, 32'hAAAABB55});
    vecs.push_back('{1'b1, 1'b0, 3'd1, 32'h12345678, 4'h0, 1'b0, 1'b0, 32'hAAAABB55});
    vecs.push_back('{1'b1, 1'b1, 3'd1, 32'h00000000, 4'h0, 1'b1, 1'b0, 32'h00000000});
    vecs.push_back('{1'b1, 1'b0, 3'd1, 32'hCAFEF00D, 4'h9, 1'b0, 1'b0, 32'h00000000});
    vecs.push_back('{1'b1, 1'b1, 3'd1, 32'h00000000, 4'h0, 1'b1, 1'b0, 32'hCA00000D});
    vecs.push_back('{1'b1, 1'b1, 3'd3, 32'h00000000, 4'h0, 1'b1, 1'b0, 32'hAAAABB55});
    vecs.push_back('{1'b0, 1'b0, 3'd0, 32'h00000000, 4'h0, 1'b0, 1'b0, 32'hAAAABB55});

    // Reset state
    rst_n = 1'b0;
    drive_a(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    drive_b(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    repeat (3) step();
    chk("rst_ready", 32'(ifa.ready), 32'd0);
    chk("rst_dout", ifa.D_Out, 32'h0);
    chk("rst_valid", 32'(ifa.valid), 32'd0);
    chk("rst_err", 32'(ifa.err), 32'd0);

    // Initial zero-fill with a write request that must be dropped
    drive_a(1'b1, 1'b0, 1'b0, 3'd0, 32'hDEADBEEF, 4'hF);
    rst_n = 1'b1;
    run_init(na, nb);
    drive_a(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    chk("init_cycles_a", 32'(na), 32'd8);
    chk("init_cycles_b", 32'(nb), 32'd6);
    read_all_a("init_zero", zeros);

    // Table-driven vectors
    foreach (vecs[i]) begin
      drive_a(vecs[i].en, vecs[i].rw, 1'b0, vecs[i].addr, vecs[i].din, vecs[i].be);
      step();
      chk($sformatf("vec%0d_valid", i), 32'(ifa.valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_err", i), 32'(ifa.err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_dout", i), ifa.D_Out, vecs[i].exp_dout);
    end

    // Back-to-back writes then back-to-back reads
    for (int a = 0; a < 8; a++) begin
      drive_a(1'b1, 1'b0, 1'b0, 3'(a), seq[a], 4'hF);
      step();
      chk($sformatf("b2b_wr_valid[%0d]", a), 32'(ifa.valid), 32'd0);
    end
    read_all_a("b2b_rd", seq);

    // Read-after-write on consecutive cycles
    drive_a(1'b1, 1'b0, 1'b0, 3'd5, 32'hA5A5A5A5, 4'hF);
    step();
    drive_a(1'b1, 1'b1, 1'b0, 3'd5, 32'h0, 4'h0);
    step();
    chk("raw_valid", 32'(ifa.valid), 32'd1);
    chk("raw_dout", ifa.D_Out, 32'hA5A5A5A5);
    drive_a(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    step();
    chk("raw_valid_pulse", 32'(ifa.valid), 32'd0);

    // Out-of-range on B (DEPTH=6)
    drive_b(1'b1, 1'b0, 3'd5, 32'h12345678, 4'hF);
    step();
    chk("b_wr5_err", 32'(ifb.err), 32'd0);
    drive_b(1'b1, 1'b1, 3'd5, 32'h0, 4'h0);
    step();
    chk("b_rd5_dout", ifb.D_Out, 32'h12345678);
    chk("b_rd5_valid", 32'(ifb.valid), 32'd1);
    drive_b(1'b1, 1'b0, 3'd6, 32'hFFFFFFFF, 4'hF);
    step();
    chk("b_wr6_err", 32'(ifb.err), 32'd1);
    chk("b_wr6_valid", 32'(ifb.valid), 32'd0);
    chk("b_wr6_dout_held", ifb.D_Out, 32'h12345678);
    drive_b(1'b1, 1'b1, 3'd7, 32'h0, 4'h0);
    step();
    chk("b_rd7_err", 32'(ifb.err), 32'd1);
    chk("b_rd7_valid", 32'(ifb.valid), 32'd0);
    chk("b_rd7_dout", ifb.D_Out, 32'h0);
    drive_b(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    step();
    chk("b_err_pulse", 32'(ifb.err), 32'd0);
    for (int a = 0; a < 6; a++) begin
      drive_b(1'b1, 1'b1, 3'(a), 32'h0, 4'h0);
      step();
      chk($sformatf("b_rd_valid[%0d]", a), 32'(ifb.valid), 32'd1);
      chk($sformatf("b_rd_err[%0d]", a), 32'(ifb.err), 32'd0);
      chk($sformatf("b_rd_dout[%0d]", a), ifb.D_Out, (a == 5) ? 32'h12345678 : 32'h0);
    end
    drive_b(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);

    // clear together with a write: write dropped, full refill
    drive_a(1'b1, 1'b0, 1'b1, 3'd2, 32'hFFFFFFFF, 4'hF);
    step();
    chk("clr_ready", 32'(ifa.ready), 32'd0);
    chk("clr_valid", 32'(ifa.valid), 32'd0);
    drive_a(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    run_init(na, nb);
    chk("clr_init_cycles", 32'(na), 32'd8);
    read_all_a("clr_zero", zeros);

    // Reset in the middle of a refill
    drive_a(1'b1, 1'b0, 1'b0, 3'd6, 32'h77777777, 4'hF);
    step();
    drive_a(1'b1, 1'b1, 1'b0, 3'd6, 32'h0, 4'h0);
    step();
    chk("pre_rst_dout", ifa.D_Out, 32'h77777777);
    drive_a(1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 4'h0);
    step();
    drive_a(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ifa.ready), 32'd0);
    chk("mid_rst_dout", ifa.D_Out, 32'h0);
    step();
    drive_a(1'b1, 1'b0, 1'b0, 3'd6, 32'h99999999, 4'hF);
    rst_n = 1'b1;
    run_init(na, nb);
    drive_a(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    chk("rst_init_cycles", 32'(na), 32'd8);
    read_all_a("rst_zero", zeros);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
